// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: one digit per DIV-cycle slot, active-low one-cold select.
// Newly loaded digits wait in a pending register and go live only at a frame boundary.
module seg_scan_driver #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned DIV    = 1000,
  parameter bit          HEX_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              blz,
  input  logic [4*NDIG-1:0] wdata,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   sel,
  output logic              frame
);

  localparam int unsigned     IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [15:0]     PRE_MAX = 16'(DIV - 1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);

  logic [15:0]       pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic              tick, wrap;
  logic [NDIG-1:0]   lz;
  logic [3:0]        code;
  logic              blank;
  logic [6:0]        seg_d;
  logic [NDIG-1:0]   sel_d;

  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'h0:    dec7 = 7'b1111110;
      4'h1:    dec7 = 7'b0110000;
      4'h2:    dec7 = 7'b1101101;
      4'h3:    dec7 = 7'b1111001;
      4'h4:    dec7 = 7'b0110011;
      4'h5:    dec7 = 7'b1011011;
      4'h6:    dec7 = 7'b1011111;
      4'h7:    dec7 = 7'b1110000;
      4'h8:    dec7 = 7'b1111111;
      4'h9:    dec7 = 7'b1111011;
      4'hA:    dec7 = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB:    dec7 = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'hC:    dec7 = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'hD:    dec7 = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'hE:    dec7 = HEX_EN ? 7'b1001111 : 7'b0000000;
      4'hF:    dec7 = HEX_EN ? 7'b1000111 : 7'b0000000;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  // Bit k set when digit k and every digit above it are zero.
  function automatic logic [NDIG-1:0] lead_zero(input logic [4*NDIG-1:0] d);
    logic z;
    lead_zero = '0;
    z = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      z = z && (d[4*k +: 4] == 4'd0);
      lead_zero[k] = z;
    end
  endfunction

  always_comb begin
    tick = en && (pre_q == PRE_MAX);
    wrap = tick && (idx_q == IDX_MAX);

    pre_d = pre_q;
    if (en) pre_d = tick ? 16'd0 : pre_q + 16'd1;

    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);

    pend_d = load ? wdata : pend_q;

    // A same-edge load bypasses pending so the freshest data goes live.
    disp_d = disp_q;
    if (wrap || !en) disp_d = pend_d;
  end

  // Output registers track next-state index/display so a new frame shows up with frame=1.
  always_comb begin
    lz    = lead_zero(disp_d);
    code  = 4'd0;
    blank = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_d == IW'(k)) begin
        code  = disp_d[4*k +: 4];
        blank = blz && (k != 0) && lz[k];
      end
    end

    seg_d = 7'b0000000;
    sel_d = '1;
    if (en) begin
      sel_d = ~(NDIG'(1) << idx_d);
      seg_d = blank ? 7'b0000000 : dec7(code);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= 16'd0;
      idx_q  <= '0;
      pend_q <= '0;
      disp_q <= '0;
      seg    <= 7'b0000000;
      sel    <= '1;
      frame  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      seg    <= seg_d;
      sel    <= sel_d;
      frame  <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: decimal and hex decoders, a single-digit instance,
// frame-aligned display updates, enable hold and asynchronous reset.
module tb_seg_scan_driver;

  logic        clk, rst, en, load, blz;
  logic [15:0] wdata;
  logic [6:0]  seg_dec, seg_hex, seg_one;
  logic [3:0]  sel_dec, sel_hex;
  logic [0:0]  sel_one;
  logic        frame_dec, frame_hex, frame_one;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [6:0] sd;
    logic [6:0] sh;
    logic [3:0] sl;
  } exp_t;

  exp_t exp_q[$];

  seg_scan_driver #(.NDIG(4), .DIV(4), .HEX_EN(1'b0)) u_dec (
    .clk(clk), .rst(rst), .en(en), .load(load), .blz(blz), .wdata(wdata),
    .seg(seg_dec), .sel(sel_dec), .frame(frame_dec)
  );

  seg_scan_driver #(.NDIG(4), .DIV(4), .HEX_EN(1'b1)) u_hex (
    .clk(clk), .rst(rst), .en(en), .load(load), .blz(blz), .wdata(wdata),
    .seg(seg_hex), .sel(sel_hex), .frame(frame_hex)
  );

  seg_scan_driver #(.NDIG(1), .DIV(4), .HEX_EN(1'b0)) u_one (
    .clk(clk), .rst(rst), .en(en), .load(load), .blz(blz), .wdata(wdata[3:0]),
    .seg(seg_one), .sel(sel_one), .frame(frame_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, got, exp);
  endtask

  task automatic push(input logic [6:0] sd, input logic [6:0] sh, input logic [3:0] sl);
    exp_t e;
    e.sd = sd;
    e.sh = sh;
    e.sl = sl;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s: observed empty scoreboard required an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_segdec"}, {1'b0, seg_dec}, {1'b0, e.sd});
      chk({tag, "_seghex"}, {1'b0, seg_hex}, {1'b0, e.sh});
      chk({tag, "_sel"}, {4'b0, sel_dec}, {4'b0, e.sl});
    end
  endtask

  task automatic wait_frame(input string tag);
    for (int n = 0; n < 64; n++) begin
      step();
      if (frame_dec) break;
    end
    chk(tag, {7'b0, frame_dec}, 8'd1);
  endtask

  // Entered in the frame=1 cycle; leaves in the first cycle of slot 3.
  task automatic check_frame(input string tag);
    for (int k = 0; k < 4; k++) begin
      pop_chk($sformatf("%s_d%0d", tag, k));
      if (k == 0) begin
        step();
        chk({tag, "_frame_width"}, {7'b0, frame_dec}, 8'd0);
        repeat (3) step();
      end else if (k < 3) begin
        repeat (4) step();
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    load  = 1'b1;
    blz   = 1'b0;
    wdata = 16'hFFFF;
    repeat (2) step();
    chk("rst_seg", {1'b0, seg_dec}, 8'd0);
    chk("rst_sel", {4'b0, sel_dec}, 8'h0F);
    chk("rst_frame", {7'b0, frame_dec}, 8'd0);
    chk("rst_sel_one", {7'b0, sel_one}, 8'd1);

    // First edge after reset selects digit 0 with the cleared display; load was ignored.
    rst  = 1'b0;
    en   = 1'b1;
    load = 1'b0;
    step();
    chk("start_seg", {1'b0, seg_dec}, {1'b0, 7'b1111110});
    chk("start_sel", {4'b0, sel_dec}, 8'b0000_1110);
    chk("start_seg_one", {1'b0, seg_one}, {1'b0, 7'b1111110});

    // Decode: 9A37 shown from the next frame.
    load  = 1'b1;
    wdata = 16'h9A37;
    push(7'b1110000, 7'b1110000, 4'b1110);
    push(7'b1111001, 7'b1111001, 4'b1101);
    push(7'b0000000, 7'b1110111, 4'b1011);
    push(7'b1111011, 7'b1111011, 4'b0111);
    step();
    load = 1'b0;
    wait_frame("dec_frame");
    check_frame("dec");

    // Hex and leading-zero blanking.
    blz   = 1'b1;
    load  = 1'b1;
    wdata = 16'h00B0;
    push(7'b1111110, 7'b1111110, 4'b1110);
    push(7'b0000000, 7'b0011111, 4'b1101);
    push(7'b0000000, 7'b0000000, 4'b1011);
    push(7'b0000000, 7'b0000000, 4'b0111);
    step();
    load = 1'b0;
    wait_frame("blz_frame");
    check_frame("blz");

    load  = 1'b1;
    wdata = 16'h0000;
    push(7'b1111110, 7'b1111110, 4'b1110);
    push(7'b0000000, 7'b0000000, 4'b1101);
    push(7'b0000000, 7'b0000000, 4'b1011);
    push(7'b0000000, 7'b0000000, 4'b0111);
    step();
    load = 1'b0;
    wait_frame("zero_frame");
    check_frame("zero");

    // Tear-free: load at index 2, old data finishes the frame.
    blz = 1'b0;
    wait_frame("tear_sync");
    chk("tear_sync_seg", {1'b0, seg_dec}, {1'b0, 7'b1111110});
    repeat (8) step();
    load  = 1'b1;
    wdata = 16'h1111;
    push(7'b1111110, 7'b1111110, 4'b1011);
    push(7'b1111110, 7'b1111110, 4'b0111);
    push(7'b0110000, 7'b0110000, 4'b1110);
    step();
    load = 1'b0;
    pop_chk("tear_d2");
    repeat (3) step();
    pop_chk("tear_d3");
    repeat (4) step();
    chk("tear_frame", {7'b0, frame_dec}, 8'd1);
    pop_chk("tear_new");

    // Enable hold at index 1 with prescaler at 1.
    repeat (5) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("en0_seg%0d", i), {1'b0, seg_dec}, 8'd0);
      chk($sformatf("en0_sel%0d", i), {4'b0, sel_dec}, 8'h0F);
    end
    en = 1'b1;
    step();
    chk("resume_seg", {1'b0, seg_dec}, {1'b0, 7'b0110000});
    chk("resume_sel", {4'b0, sel_dec}, 8'b0000_1101);
    step();
    chk("resume_sel_hold", {4'b0, sel_dec}, 8'b0000_1101);
    step();
    chk("resume_sel_next", {4'b0, sel_dec}, 8'b0000_1011);

    // Load coinciding with the wrapping tick.
    wait_frame("sim_sync");
    repeat (15) step();
    load  = 1'b1;
    wdata = 16'h2222;
    push(7'b1101101, 7'b1101101, 4'b1110);
    step();
    load = 1'b0;
    chk("sim_frame", {7'b0, frame_dec}, 8'd1);
    pop_chk("sim");
    chk("one_frame", {7'b0, frame_one}, 8'd1);
    chk("one_seg", {1'b0, seg_one}, {1'b0, 7'b1101101});
    chk("one_sel", {7'b0, sel_one}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("one_gap%0d", i), {7'b0, frame_one}, 8'd0);
    end
    step();
    chk("one_period", {7'b0, frame_one}, 8'd1);

    // Asynchronous reset mid-slot discards pending data.
    load  = 1'b1;
    wdata = 16'h5555;
    step();
    load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_seg", {1'b0, seg_dec}, 8'd0);
    chk("arst_sel", {4'b0, sel_dec}, 8'h0F);
    chk("arst_frame", {7'b0, frame_dec}, 8'd0);
    chk("arst_seg_one", {1'b0, seg_one}, 8'd0);
    rst = 1'b0;
    step();
    chk("post_rst_seg", {1'b0, seg_dec}, {1'b0, 7'b1111110});
    chk("post_rst_sel", {4'b0, sel_dec}, 8'b0000_1110);
    chk("post_rst_seg_one", {1'b0, seg_one}, {1'b0, 7'b1111110});
    wait_frame("post_rst_frame");
    chk("post_rst_lost_dec", {1'b0, seg_dec}, {1'b0, 7'b1111110});
    chk("post_rst_lost_hex", {1'b0, seg_hex}, {1'b0, 7'b1111110});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, giving the number of digits scanned (legal 1..8).
REQ-002 The block SHALL have parameter DIV, default 1000, giving clock cycles per digit slot (legal 2..65535).
REQ-003 The block SHALL have parameter HEX_EN, default 0: 1 = codes 10..15 shown as A,b,C,d,E,F; 0 = codes 10..15 blanked.
REQ-004 Ports, in order:
  clk     input   1        system clock, rising edge
  rst     input   1        reset, asynchronous, active-high
  en      input   1        scan enable
  load    input   1        capture wdata into pending register
  blz     input   1        leading-zero blanking enable
  wdata   input   4*NDIG   digit codes; digit k = wdata[4k+3:4k], digit 0 rightmost
  seg     output  7        segments {a,b,c,d,e,f,g}, a = MSB, active-high
  sel     output  NDIG     digit select, active-low, one-cold
  frame   output  1        one-cycle pulse when the scan wraps to digit 0
REQ-005 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-high on rst.

Function
REQ-006 The prescaler SHALL count 0..DIV-1 while en=1, wrap to 0, and hold its value while en=0.
REQ-007 A tick SHALL occur in the cycle the prescaler equals DIV-1 with en=1.
REQ-008 The digit index SHALL advance on each tick, from 0 to NDIG-1, and wrap from NDIG-1 to 0.
REQ-009 frame SHALL be 1 in the cycle after a tick that wraps the index to 0, and 0 otherwise.
REQ-010 load=1 SHALL capture wdata into the pending register at the clock edge; the last load before the transfer wins.
REQ-011 Pending SHALL transfer to the display register on a wrapping tick, or on any edge while en=0; this prevents mid-frame tearing.
REQ-012 If load and the transfer occur on the same edge, the display register SHALL receive the new wdata, not the old pending value.
REQ-013 seg and sel SHALL be registered and SHALL reflect the current index and display register one cycle after the index changes.
REQ-014 sel SHALL drive bit[index]=0 and all other bits to 1 while en=1.
REQ-015 Codes 0..9 SHALL decode to 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000, 8:1111111, 9:1111011.
REQ-016 With HEX_EN=1, codes 10..15 SHALL decode to A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111.
REQ-017 With HEX_EN=0, codes 10..15 SHALL decode to 0000000; seg SHALL never be X.
REQ-018 With blz=1, a digit k>0 SHALL show seg=0000000 when digit k and every digit above k hold code 0.
REQ-019 Digit 0 SHALL never be leading-zero blanked.
REQ-020 While en=0, seg SHALL be 0000000, sel SHALL be all ones, and the prescaler and index SHALL hold their values.
REQ-021 When en returns to 1, scanning SHALL resume from the held index and prescaler value.
REQ-022 With NDIG=1, the index SHALL stay 0 and every tick SHALL be a wrapping tick, so frame pulses once per DIV cycles.

Reset
REQ-023 While rst=1, the block SHALL force prescaler=0, index=0, pending=0, display=0, seg=0000000, sel=all ones, and frame=0.
REQ-024 rst SHALL override en and load; a rst asserted mid-frame SHALL discard pending data.
REQ-025 In the first edge after rst falls with en=1, the block SHALL drive sel to select digit 0 and seg to show display digit 0.

Verification
REQ-026 Decode test (NDIG=4, DIV=4, HEX_EN=0, blz=0): load wdata=16'h9A37 -> after one frame, slots 0..3 show 1110000, 1111001, 0000000, 1111011; sel cycles 1110, 1101, 1011, 0111.
REQ-027 Hex and blanking test (HEX_EN=1, blz=1): wdata=16'h00B0 -> digit0=1111110, digit1=0011111, digits 2 and 3=0000000; then wdata=16'h0000 -> only digit0 lit, showing 1111110.
REQ-028 Tear-free test: load 16'h1111 while the index is 2 -> digits 2 and 3 of the current frame keep the old value; the new value appears from the next frame start, coincident with frame=1.
REQ-029 Enable test: deassert en for 10 cycles at index 1 -> seg=0000000 and sel=1111 throughout; resume at index 1 with the prescaler unchanged.
REQ-030 Reset test: assert rst asynchronously mid-slot -> all outputs reach reset values before the next clk edge; loaded data is lost and digit 0 then shows 1111110.
REQ-031 Simultaneous-event test: load on the wrapping-tick edge -> the display register takes the new wdata; NDIG=1 -> frame pulses every DIV cycles.
